quad_step_decoder: RTL and testbench
====================================

// Module: quad_step_decoder
// PURPOSE
//  Upstream feeder for the 8-bit up/down counter. Takes raw async quadrature encoder lines A/B.
//  Synchronises and glitch-filters both lines, then decodes x4 quadrature.
//  Emits a 1-cycle step pulse with a held direction bit (ud) every STEP_DIV quarter-counts, one per detent.
//  Illegal transitions (both lines changing at once) raise a sticky error flag.
// PARAMETERS
//  FILT_CYCLES  4  consecutive cycles a synced line must differ from its filtered value before the filtered value updates (>=1)
//  STEP_DIV     4  quarter-counts per emitted step (1..8)
// PORTS
//  clk      in   1  system clock, all logic on posedge
//  reset    in   1  one clock; reset is synchronous and active-low
//  enc_a    in   1  raw encoder channel A, asynchronous
//  enc_b    in   1  raw encoder channel B, asynchronous
//  err_clr  in   1  clears err (synchronous, level)
//  step     out  1  one-cycle pulse: count one in direction ud
//  ud       out  1  direction of last step: 1=up, 0=down; held between steps
//  err      out  1  sticky illegal-transition flag
//  busy     out  1  1 while in INIT (decoder not yet tracking)
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - all flops clear: sync stages, a_f/b_f, filter counters, acc, prev, step, ud, err.
//   - FSM enters INIT; busy=1.
//  Sync: two flops per channel give a_s, b_s, 2 cycles after the pin.
//  FSM INIT:
//   - a_f<=a_s and b_f<=b_s every cycle, unfiltered.
//   - Timer counts cycles with {a_s,b_s} unchanged and restarts on any change.
//   - When the timer reaches FILT_CYCLES: prev<={a_f,b_f}, acc<=0, go TRACK.
//   - No step or err is generated in INIT.
//  FSM TRACK, filter per channel:
//   - If x_s==x_f, the counter clears.
//   - Otherwise the counter increments; when it reaches FILT_CYCLES, x_f<=x_s and the counter clears.
//   - A 1-cycle glitch (any pulse shorter than FILT_CYCLES) never changes x_f.
//  Decode in TRACK, comparing cur={a_f,b_f} against prev each cycle:
//   - Up sequence: 00->10->11->01->00 (A leads). Down: the reverse.
//   - Legal up move: acc+=1. Legal down move: acc-=1.
//   - Both bits differ: illegal. err<=1, acc<=0, no step.
//   - Every cycle, prev<=cur.
//   - acc is signed, $clog2(STEP_DIV)+2 bits.
//   - When the updated acc reaches +STEP_DIV: step<=1, ud<=1, acc<=0.
//   - When the updated acc reaches -STEP_DIV: step<=1, ud<=0, acc<=0.
//   - Direction reversal mid-detent simply walks acc back; no step until +/-STEP_DIV is reached.
//  Outputs:
//   - step is registered: high exactly 1 cycle, the cycle after the qualifying filtered change.
//   - ud changes only in the same cycle step asserts.
//  Latency, pin edge to step: 2 (sync) + FILT_CYCLES (filter) + 1 (decode) cycles; 7 at defaults.
//  err:
//   - Set by an illegal move; cleared by err_clr==1.
//   - Simultaneous set and clear: set wins.
//   - Unaffected by step.
//  Simultaneous filter updates on A and B in the same cycle are treated as illegal, even if caused by skew.
//  Reset mid-operation:
//   - Any in-flight acc, pending filter count or step is discarded.
//   - Returns to INIT on the next cycle with reset high; no spurious step or err after reset.
//  Maximum trackable rate: one filtered edge per FILT_CYCLES+1 cycles per channel. Faster inputs are filtered out or flagged.
// TESTING
//  1 Reset with A=B=1 held: busy=1 for 2+4 cycles, then 0. No step, err=0, ud=0.
//  2 One detent up (00->10->11->01->00, 20 cycles per phase): exactly one step pulse, ud=1, asserted 7 cycles after the final edge.
//  3 Two detents down: two step pulses, ud=0. Then half detent up, then back down: no step, acc returns to 0.
//  4 3-cycle glitch on A while idle: no filtered change, no step, err=0. 4-cycle pulse: filtered edge seen, acc=+1.
//  5 A and B toggled on the same clock: err=1, no step. err_clr and a new illegal move in the same cycle: err stays 1. err_clr alone: err=0.
//  6 Assert reset after 3 quarter-counts up: no step. After INIT, 1 more quarter-count gives no step (acc restarted at 0).

Source files
------------

// File: rtl/quad_step_decoder_if.sv
// Bundle of the encoder-side signals of quad_step_decoder.
// Latency: none (wires only).
// Backpressure: none; the encoder lines are free-running.
// master: drives enc_a/enc_b (raw, async) and err_clr; observes step/ud/err/busy.
// slave : the decoder; samples the inputs and drives step/ud/err/busy.
interface quad_step_decoder_if;
    logic enc_a;
    logic enc_b;
    logic err_clr;
    logic step;
    logic ud;
    logic err;
    logic busy;

    modport master (output enc_a, enc_b, err_clr, input step, ud, err, busy);
    modport slave  (input enc_a, enc_b, err_clr, output step, ud, err, busy);
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature (x4) decoder: sync + glitch filter on A/B, one step pulse per STEP_DIV quarter-counts.
// Latency: pin edge to step = 2 (sync) + FILT_CYCLES (filter) + 1 (decode) cycles.
// Backpressure: none; step is a 1-cycle pulse, inputs faster than the filter allows are dropped or flagged.
// Ports: clk, reset (sync, active-low), enc (slave modport): enc_a/enc_b raw lines, err_clr level clear,
//        step pulse, ud direction of last step (1=up), err sticky illegal-move flag, busy while in INIT.
module quad_step_decoder #(
    parameter int FILT_CYCLES = 4,
    parameter int STEP_DIV    = 4
) (
    input  logic               clk,
    input  logic               reset,
    quad_step_decoder_if.slave enc
);
    localparam int CW = $clog2(FILT_CYCLES + 1);
    localparam int AW = $clog2(STEP_DIV) + 2;
    localparam logic [CW-1:0]        FILT_LAST = CW'(FILT_CYCLES - 1);
    localparam logic signed [AW-1:0] ACC_ONE   = AW'(1);
    localparam logic signed [AW-1:0] ACC_POS   = AW'(STEP_DIV);
    localparam logic signed [AW-1:0] ACC_NEG   = AW'(-STEP_DIV);

    typedef enum logic {ST_INIT, ST_TRACK} state_t;

    state_t                 state_q, state_d;
    logic                   a_m_q, a_m_d, a_s_q, a_s_d;
    logic                   b_m_q, b_m_d, b_s_q, b_s_d;
    logic                   a_f_q, a_f_d, b_f_q, b_f_d;
    logic [CW-1:0]          a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic [CW-1:0]          timer_q, timer_d;
    logic [1:0]             prev_q, prev_d;
    logic signed [AW-1:0]   acc_q, acc_d, acc_nxt;
    logic                   step_q, step_d;
    logic                   ud_q, ud_d;
    logic                   err_q, err_d;

    always_comb begin
        a_m_d   = enc.enc_a;
        b_m_d   = enc.enc_b;
        a_s_d   = a_m_q;
        b_s_d   = b_m_q;
        state_d = state_q;
        a_f_d   = a_f_q;
        b_f_d   = b_f_q;
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        timer_d = timer_q;
        prev_d  = prev_q;
        acc_d   = acc_q;
        acc_nxt = acc_q;
        step_d  = 1'b0;
        ud_d    = ud_q;
        err_d   = err_q;

        // Clear first so that an illegal move in the same cycle overrides it.
        if (enc.err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_INIT: begin
                // Filtered values track the synced lines directly, so a_f/b_f hold
                // last cycle's synced value and double as the change detector.
                a_f_d   = a_s_q;
                b_f_d   = b_s_q;
                a_cnt_d = '0;
                b_cnt_d = '0;
                if ({a_s_q, b_s_q} != {a_f_q, b_f_q}) begin
                    timer_d = '0;
                end else if (timer_q == FILT_LAST) begin
                    timer_d = '0;
                    prev_d  = {a_f_q, b_f_q};
                    acc_d   = '0;
                    state_d = ST_TRACK;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_TRACK: begin
                if (a_s_q == a_f_q) begin
                    a_cnt_d = '0;
                end else if (a_cnt_q == FILT_LAST) begin
                    a_f_d   = a_s_q;
                    a_cnt_d = '0;
                end else begin
                    a_cnt_d = a_cnt_q + 1'b1;
                end

                if (b_s_q == b_f_q) begin
                    b_cnt_d = '0;
                end else if (b_cnt_q == FILT_LAST) begin
                    b_f_d   = b_s_q;
                    b_cnt_d = '0;
                end else begin
                    b_cnt_d = b_cnt_q + 1'b1;
                end

                // {prev, cur} with cur = {a_f, b_f}; A leads on an up move.
                prev_d = {a_f_q, b_f_q};
                case ({prev_q, a_f_q, b_f_q})
                    4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: acc_nxt = acc_q + ACC_ONE;
                    4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: acc_nxt = acc_q - ACC_ONE;
                    4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: begin
                        acc_nxt = '0;
                        err_d   = 1'b1;
                    end
                    default: acc_nxt = acc_q;
                endcase

                if (acc_nxt == ACC_POS) begin
                    step_d = 1'b1;
                    ud_d   = 1'b1;
                    acc_d  = '0;
                end else if (acc_nxt == ACC_NEG) begin
                    step_d = 1'b1;
                    ud_d   = 1'b0;
                    acc_d  = '0;
                end else begin
                    acc_d  = acc_nxt;
                end
            end

            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_INIT;
            a_m_q   <= 1'b0;
            a_s_q   <= 1'b0;
            b_m_q   <= 1'b0;
            b_s_q   <= 1'b0;
            a_f_q   <= 1'b0;
            b_f_q   <= 1'b0;
            a_cnt_q <= '0;
            b_cnt_q <= '0;
            timer_q <= '0;
            prev_q  <= '0;
            acc_q   <= '0;
            step_q  <= 1'b0;
            ud_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_m_q   <= a_m_d;
            a_s_q   <= a_s_d;
            b_m_q   <= b_m_d;
            b_s_q   <= b_s_d;
            a_f_q   <= a_f_d;
            b_f_q   <= b_f_d;
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
            timer_q <= timer_d;
            prev_q  <= prev_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            ud_q    <= ud_d;
            err_q   <= err_d;
        end
    end

    assign enc.step = step_q;
    assign enc.ud   = ud_q;
    assign enc.err  = err_q;
    assign enc.busy = (state_q == ST_INIT);
endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: pin-level stimulus, position/accumulator reference model,
// expected steps queued with their due cycle and checked by an independent monitor.
module tb_quad_step_decoder;
    localparam int FILT = 4;
    localparam int SDIV = 4;
    localparam int LAT  = 2 + FILT + 1;
    // Positions of {A,B} along the up direction.
    localparam logic [1:0] SEQ [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    logic clk = 1'b0;
    logic reset = 1'b0;
    quad_step_decoder_if bus();

    quad_step_decoder #(.FILT_CYCLES(FILT), .STEP_DIV(SDIV)) dut (
        .clk   (clk),
        .reset (reset),
        .enc   (bus.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int t; logic ud; } exp_t;
    exp_t exp_q[$];

    logic [1:0] m_pos;
    int         m_acc;
    logic       m_err;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every step pulse must match the oldest expected step, in time and direction.
    always @(negedge clk) begin
        if (bus.step === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_step: step=1 at cycle %0d, expected no step", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("step_cycle", cyc, e.t);
                check("step_ud", bus.ud, e.ud);
            end
        end
    end

    function automatic int pos_idx(logic [1:0] p);
        for (int i = 0; i < 4; i++) begin
            if (SEQ[i] == p) return i;
        end
        return 0;
    endfunction

    // Reference model: called at the cycle the new pin state is driven.
    task automatic model_move(logic [1:0] nxt);
        int d;
        if (nxt == m_pos) return;
        d = (pos_idx(nxt) - pos_idx(m_pos) + 4) % 4;
        if (d == 2) begin
            m_err = 1'b1;
            m_acc = 0;
        end else begin
            m_acc += (d == 1) ? 1 : -1;
            if (m_acc == SDIV || m_acc == -SDIV) begin
                exp_q.push_back('{t: cyc + LAT, ud: (m_acc > 0)});
                m_acc = 0;
            end
        end
        m_pos = nxt;
    endtask

    // Drive a pin state for 'hold' samples; holds shorter than FILT are glitches.
    task automatic move(logic [1:0] nxt, int hold);
        @(posedge clk); #1;
        if (hold >= FILT) model_move(nxt);
        bus.enc_a = nxt[1];
        bus.enc_b = nxt[0];
        repeat (hold - 1) @(posedge clk);
    endtask

    task automatic do_reset(logic [1:0] p);
        @(posedge clk); #1;
        reset       = 1'b0;
        bus.enc_a   = p[1];
        bus.enc_b   = p[0];
        bus.err_clr = 1'b0;
        exp_q.delete();
        m_acc = 0;
        m_err = 1'b0;
        m_pos = p;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 1);
        check("rst_step", bus.step, 0);
        check("rst_err", bus.err, 0);
        check("rst_ud", bus.ud, 0);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic wait_track();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL init_timeout: busy=%b after %0d cycles, expected 0", bus.busy, n);
        end
    endtask

    task automatic settle();
        repeat (LAT + 4) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] cur;
        int         idx;
        bus.enc_a   = 1'b0;
        bus.enc_b   = 1'b0;
        bus.err_clr = 1'b0;

        // 1: reset with A=B=1; busy stays high while the lines sync and settle.
        do_reset(2'b11);
        repeat (2 + FILT) begin
            @(negedge clk);
            check("init_busy", bus.busy, 1);
        end
        wait_track();
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t1_err", bus.err, 0);
        check("t1_ud", bus.ud, 0);

        // 2: one detent up.
        do_reset(2'b00);
        wait_track();
        move(2'b10, 20); move(2'b11, 20); move(2'b01, 20); move(2'b00, 20);
        settle();
        check("t2_ud", bus.ud, 1);

        // 3: two detents down, half up and back, then one more detent down.
        for (int k = 0; k < 2; k++) begin
            move(2'b01, 20); move(2'b11, 20); move(2'b10, 20); move(2'b00, 20);
        end
        settle();
        check("t3_ud", bus.ud, 0);
        move(2'b10, 20); move(2'b11, 20); move(2'b10, 20); move(2'b00, 20);
        move(2'b01, 20); move(2'b11, 20); move(2'b10, 20); move(2'b00, 20);
        settle();
        check("t3_err", bus.err, 0);

        // 4: walk to acc=-3 at 10, then glitches on A; a full-length pulse completes a detent.
        move(2'b01, 20); move(2'b11, 20); move(2'b10, 20);
        move(2'b00, $urandom_range(1, FILT - 1)); move(2'b10, 20);
        move(2'b00, FILT - 1); move(2'b10, 20);
        settle();
        check("t4_glitch_err", bus.err, 0);
        move(2'b00, FILT); move(2'b10, 20);
        settle();
        check("t4_pulse_ud", bus.ud, 0);
        check("t4_err", bus.err, 0);

        // 5: illegal moves and err_clr priority.
        move(2'b01, 20);
        settle();
        check("t5_err_set", bus.err, m_err);
        @(posedge clk); #1;
        model_move(2'b10);
        bus.enc_a = 1'b1;
        bus.enc_b = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1 bus.err_clr = 1'b1;
        @(posedge clk); #1 bus.err_clr = 1'b0;
        settle();
        check("t5_set_wins", bus.err, m_err);
        @(posedge clk); #1 bus.err_clr = 1'b1;
        m_err = 1'b0;
        @(posedge clk); #1 bus.err_clr = 1'b0;
        @(negedge clk);
        check("t5_clr", bus.err, m_err);

        // Random walk with occasional illegal jumps.
        for (int k = 0; k < 60; k++) begin
            cur = {bus.enc_a, bus.enc_b};
            idx = pos_idx(cur);
            if ($urandom_range(0, 9) == 0)
                move(~cur, $urandom_range(FILT + 1, 25));
            else if ($urandom_range(0, 1) == 1)
                move(SEQ[(idx + 1) % 4], $urandom_range(FILT + 1, 25));
            else
                move(SEQ[(idx + 3) % 4], $urandom_range(FILT + 1, 25));
        end
        settle();
        check("rand_err", bus.err, m_err);

        // 6: reset after three quarter-counts discards the accumulator.
        do_reset(2'b00);
        wait_track();
        move(2'b10, 20); move(2'b11, 20); move(2'b01, 20);
        do_reset(2'b01);
        wait_track();
        move(2'b00, 20);
        settle();
        check("t6_err", bus.err, 0);
        check("t6_ud", bus.ud, 0);

        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_step: %0d expected steps never seen, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
